spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
- Serial front-end of the SPI slave path, clocked by SCLK.
- Deserialises 16-bit command frames (R/W, 7-bit address, 8-bit data) framed by SV_n.
- Issues one-cycle write strobes and read requests to the downstream 8-bit register bank, and serialises the returned read data onto SO.
- Counts bits, rejects malformed frames and keeps a saturating error count. Holds no configuration registers itself.

Parameters:
- ADDR_W, 7, register address width.
- DATA_W, 8, register data width; frame length is FRAME_BITS = 1+ADDR_W+DATA_W (16).
- ERR_W, 8, width of the saturating frame-error counter.

Ports:
- SCLK  in  1  free-running serial clock; all state on posedge except the SO shifter (negedge).
- rst_n  in  1  reset, asynchronous, active-low.
- SV_n  in  1  frame select, active-low; sampled on posedge SCLK.
- SI  in  1  serial data in, MSB first; sampled on posedge SCLK.
- SO  out  1  serial data out, MSB first; updated on negedge SCLK.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_W  write address, valid with wr_en.
- wr_data  out  DATA_W  write data, valid with wr_en.
- rd_req  out  1  one-cycle read request.
- rd_addr  out  ADDR_W  read address, valid with rd_req and held until the frame ends.
- rd_data  in  DATA_W  combinational read data from the register bank; must be valid while rd_req=1.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- err_cnt  out  ERR_W  saturating count of malformed frames.
- busy  out  1  high from frame start until commit or abort completes.

Behaviour:
- Reset: all outputs 0, shift register 0, bit counter 0, FSM in IDLE. Reset asserted mid-frame discards the frame; no wr_en or rd_req is issued.
- Frame format: bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = data (ignored for reads).
- FSM states:
  - IDLE: a sampled SV_n=0 enters SHIFT. The bit captured on that same edge counts as bit 1.
  - SHIFT: each posedge with SV_n=0 shifts SI into sh_in[15:0] and increments bitcnt. bitcnt is 5 bits and saturates at 17.
  - SHIFT exit: sampled SV_n=1 goes to COMMIT if bitcnt==16, otherwise to ERR.
  - COMMIT: for a write frame, wr_en=1 for exactly one cycle with wr_addr=sh_in[14:8] and wr_data=sh_in[7:0]. For a read frame nothing is issued. Then IDLE.
  - ERR: frame_err=1 for one cycle; err_cnt increments, saturating at 2^ERR_W-1. Then IDLE. No wr_en.
- Read path:
  - On the posedge where bitcnt becomes 8 with sh_in bit7 (the R/W bit) = 1, latch rd_addr = the low 7 captured bits.
  - rd_req=1 during the following cycle only.
  - On the negedge inside that cycle, load {SO, sh_out[6:0]} <= rd_data. Each later negedge shifts sh_out left into SO, filling with 0.
  - Net timing: rd_data[7] is on SO before the posedge that samples bit 9, and rd_data[0] is valid before the posedge that samples bit 16.
- SO is 0 outside read data phases. A read frame that is aborted is still counted as an error; its rd_req has already occurred and is not retracted.
- busy = (state != IDLE).
- A frame longer than 16 bits is an error. SV_n high for a single sample terminates the frame.
- Back-to-back frames: SV_n low on the cycle immediately after COMMIT or ERR is accepted and starts a new frame from IDLE.
- An SV_n low sample during COMMIT or ERR is ignored. Masters must keep SV_n high for at least 2 SCLK cycles between frames.
- wr_en, rd_req and frame_err are mutually exclusive in any cycle.

Decomposition:
- Shared package spi_pkg:
  - FSM state enum {IDLE, SHIFT, COMMIT, ERR}.
  - Constants ADDR_W, DATA_W, FRAME_BITS, and RW_BIT = 15.
  - Register address constants shared with the register bank (0x00–0x07).
- One natural sub-module: spi_tx_shifter. It is the negedge load/shift serializer for SO, with inputs load and rd_data and output SO.

Test Plan:
- Write frame 0x0305 (addr 3, data 0x05), 16 bits, then SV_n high -> single wr_en with wr_addr=3 and wr_data=0x05, two cycles after the last bit; frame_err stays 0.
- Read frame 0x8200 with rd_data=0xA5 returned while rd_addr=2 -> rd_req pulse in the cycle after bit 8; SO over bits 9–16 = 1,0,1,0,0,1,0,1; no wr_en.
- 12-bit write frame then SV_n high -> no wr_en; frame_err pulse; err_cnt 0->1.
- 20-bit frame -> frame_err; err_cnt increments. With err_cnt preset by 255 bad frames, one more bad frame -> err_cnt stays 0xFF.
- rst_n low after bit 10 of write 0x07FF -> all outputs 0 asynchronously; after release, a clean write 0x0711 -> wr_addr=7, wr_data=0x11.
- Two write frames 0x0001 and 0x0102 separated by 2 SV_n-high cycles -> two wr_en pulses in order, with the correct addr/data for each.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave path: frame FSM states, frame geometry
// and the register-bank address map.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    ERR
  } state_t;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
  localparam int RW_BIT     = FRAME_BITS - 1;

  localparam logic [ADDR_W-1:0] REG_ID     = 7'h00;
  localparam logic [ADDR_W-1:0] REG_CTRL   = 7'h01;
  localparam logic [ADDR_W-1:0] REG_STATUS = 7'h02;
  localparam logic [ADDR_W-1:0] REG_IRQ_EN = 7'h03;
  localparam logic [ADDR_W-1:0] REG_IRQ_ST = 7'h04;
  localparam logic [ADDR_W-1:0] REG_SCRATCH0 = 7'h05;
  localparam logic [ADDR_W-1:0] REG_SCRATCH1 = 7'h06;
  localparam logic [ADDR_W-1:0] REG_SCRATCH2 = 7'h07;

endpackage

// File: rtl/spi_tx_shifter.sv
// Negedge serializer for SO: parallel load of read data, then MSB-first shift
// with zero fill; forced to zero outside the shifting phase of a frame.
module spi_tx_shifter #(
  parameter int DATA_W = spi_pkg::DATA_W
) (
  input  logic              SCLK,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              SO
);

  logic [DATA_W-2:0] sh_out;

  always_ff @(negedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      {SO, sh_out} <= '0;
    end else if (load) begin
      {SO, sh_out} <= rd_data;
    end else if (clr) begin
      {SO, sh_out} <= '0;
    end else begin
      {SO, sh_out} <= {sh_out, 1'b0};
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: deserialises R/W + address + data frames, issues
// register-bank write strobes and read requests, and counts malformed frames.
module spi_frame_rx #(
  parameter int ADDR_W = spi_pkg::ADDR_W,
  parameter int DATA_W = spi_pkg::DATA_W,
  parameter int ERR_W  = 8
) (
  input  logic              SCLK,
  input  logic              rst_n,
  input  logic              SV_n,
  input  logic              SI,
  output logic              SO,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              busy
);

  import spi_pkg::*;

  localparam int FRM_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRM_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRM_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRM_W + 1);
  // Count before the edge that captures the last address bit.
  localparam logic [CNT_W-1:0] CNT_RD   = CNT_W'(ADDR_W);

  state_t            state, state_nx;
  logic [FRM_W-1:0]  sh_in, sh_in_nx;
  logic [CNT_W-1:0]  bitcnt;
  logic              start, shift, commit_go, err_go, rd_go;

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  assign sh_in_nx = {sh_in[FRM_W-2:0], SI};
  assign busy     = (state != IDLE);

  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    shift     = 1'b0;
    commit_go = 1'b0;
    err_go    = 1'b0;
    rd_go     = 1'b0;
    case (state)
      IDLE: begin
        if (!SV_n) begin
          state_nx = SHIFT;
          start    = 1'b1;
        end
      end
      SHIFT: begin
        if (!SV_n) begin
          shift = 1'b1;
          // R/W bit sits one below its final slot until this edge shifts it up.
          rd_go = (bitcnt == CNT_RD) && sh_in[ADDR_W-1];
        end else if (bitcnt == CNT_FULL) begin
          state_nx  = COMMIT;
          commit_go = 1'b1;
        end else begin
          state_nx = ERR;
          err_go   = 1'b1;
        end
      end
      COMMIT:  state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      sh_in     <= '0;
      bitcnt    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      wr_en     <= 1'b0;
      rd_req    <= 1'b0;
      frame_err <= 1'b0;
      if (start) begin
        sh_in  <= {{(FRM_W-1){1'b0}}, SI};
        bitcnt <= CNT_W'(1);
      end else if (shift) begin
        sh_in  <= sh_in_nx;
        bitcnt <= cnt_sat_inc(bitcnt);
      end
      if (rd_go) begin
        rd_req  <= 1'b1;
        rd_addr <= sh_in_nx[ADDR_W-1:0];
      end
      if (commit_go && !sh_in[FRM_W-1]) begin
        wr_en   <= 1'b1;
        wr_addr <= sh_in[FRM_W-2:DATA_W];
        wr_data <= sh_in[DATA_W-1:0];
      end
      if (err_go) begin
        frame_err <= 1'b1;
        err_cnt   <= err_sat_inc(err_cnt);
      end
    end
  end

  spi_tx_shifter #(
    .DATA_W(DATA_W)
  ) u_tx (
    .SCLK    (SCLK),
    .rst_n   (rst_n),
    .load    (rd_req),
    .clr     (state != SHIFT),
    .rd_data (rd_data),
    .SO      (SO)
  );

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: table of frames with expected strobes, a negedge
// scoreboard for wr/rd/err events, and hand sequences for saturation and reset.
module tb_spi_frame_rx;

  logic       SCLK;
  logic       rst_n;
  logic       SV_n;
  logic       SI;
  logic       SO;
  logic       wr_en;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;

  logic [7:0] regs [128];
  assign rd_data = regs[rd_addr];

  spi_frame_rx dut (
    .SCLK      (SCLK),
    .rst_n     (rst_n),
    .SV_n      (SV_n),
    .SI        (SI),
    .SO        (SO),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  typedef struct {
    logic [31:0] bits;
    int          n;
    logic        exp_wr;
    logic [6:0]  exp_addr;
    logic [7:0]  exp_data;
    logic        exp_rd;
    logic [6:0]  exp_raddr;
    logic [7:0]  exp_so;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [14:0] wr_q [$];
  logic [6:0]  rd_q [$];
  logic [7:0]  err_q [$];
  logic [14:0] wexp;
  logic [6:0]  rexp;
  logic [7:0]  eexp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop expectations as the DUT strobes appear.
  always @(negedge SCLK) begin
    if (wr_en) begin
      chk("wr_expected", 64'(wr_q.size() != 0), 64'(1));
      if (wr_q.size() != 0) begin
        wexp = wr_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(wexp[14:8]));
        chk("wr_data", 64'(wr_data), 64'(wexp[7:0]));
      end
    end
    if (rd_req) begin
      chk("rd_expected", 64'(rd_q.size() != 0), 64'(1));
      if (rd_q.size() != 0) begin
        rexp = rd_q.pop_front();
        chk("rd_addr", 64'(rd_addr), 64'(rexp));
      end
    end
    if (frame_err) begin
      chk("err_expected", 64'(err_q.size() != 0), 64'(1));
      if (err_q.size() != 0) begin
        eexp = err_q.pop_front();
        chk("err_cnt", 64'(err_cnt), 64'(eexp));
      end
    end
    if (wr_en || rd_req || frame_err)
      chk("strobe_excl", 64'(32'(wr_en) + 32'(rd_req) + 32'(frame_err)), 64'(1));
  end

  task automatic send(input vec_t v);
    logic [7:0] so_b;
    so_b = '0;
    if (v.exp_wr)  wr_q.push_back({v.exp_addr, v.exp_data});
    if (v.exp_rd)  rd_q.push_back(v.exp_raddr);
    if (v.exp_err) err_q.push_back(v.exp_cnt);
    for (int i = 0; i < v.n; i++) begin
      SV_n = 1'b0;
      SI   = v.bits[v.n-1-i];
      @(posedge SCLK);
      if (i + 1 >= 9 && i + 1 <= 16) so_b[16-(i+1)] = SO;
      #1;
      if (i + 1 == 1) chk("busy_start", 64'(busy), 64'(1));
      if (i + 1 == 8) chk("rd_req_bit8", 64'(rd_req), 64'(v.exp_rd));
      if (i + 1 == 9) chk("rd_req_bit9", 64'(rd_req), 64'(0));
    end
    chk("wr_before_end", 64'(wr_en), 64'(0));
    SV_n = 1'b1;
    SI   = 1'b0;
    @(posedge SCLK); #1;
    chk("wr_pulse", 64'(wr_en), 64'(v.exp_wr));
    chk("err_pulse", 64'(frame_err), 64'(v.exp_err));
    @(posedge SCLK); #1;
    chk("wr_after", 64'(wr_en), 64'(0));
    chk("err_after", 64'(frame_err), 64'(0));
    chk("busy_end", 64'(busy), 64'(0));
    chk("so_idle", 64'(SO), 64'(0));
    if (v.exp_rd && v.n == 16) chk("so_data", 64'(so_b), 64'(v.exp_so));
  endtask

  vec_t       vt [10];
  vec_t       sv;
  int         ecnt;
  logic [15:0] rb;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[2] = 8'hA5;
    regs[3] = 8'h5A;
    regs[4] = 8'h3C;

    //         bits        n   wr    addr    data   rd    raddr   so     err   cnt
    vt[0] = '{32'h0305,   16, 1'b1, 7'h03, 8'h05, 1'b0, 7'h00, 8'h00, 1'b0, 8'd0};
    vt[1] = '{32'h8200,   16, 1'b0, 7'h00, 8'h00, 1'b1, 7'h02, 8'hA5, 1'b0, 8'd0};
    vt[2] = '{32'h0305,   12, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 8'd1};
    vt[3] = '{32'h12345,  20, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 8'd2};
    vt[4] = '{32'h0001,   16, 1'b1, 7'h00, 8'h01, 1'b0, 7'h00, 8'h00, 1'b0, 8'd0};
    vt[5] = '{32'h0102,   16, 1'b1, 7'h01, 8'h02, 1'b0, 7'h00, 8'h00, 1'b0, 8'd0};
    vt[6] = '{32'h8412,   16, 1'b0, 7'h00, 8'h00, 1'b1, 7'h04, 8'h3C, 1'b0, 8'd0};
    vt[7] = '{32'h020D,   10, 1'b0, 7'h00, 8'h00, 1'b1, 7'h03, 8'h00, 1'b1, 8'd3};
    vt[8] = '{32'h7FAB,   16, 1'b1, 7'h7F, 8'hAB, 1'b0, 7'h00, 8'h00, 1'b0, 8'd0};
    vt[9] = '{32'h83FF,   16, 1'b0, 7'h00, 8'h00, 1'b1, 7'h03, 8'h5A, 1'b0, 8'd0};

    rst_n = 1'b0;
    SV_n  = 1'b1;
    SI    = 1'b0;
    repeat (2) @(posedge SCLK);
    #1;
    chk("reset_outputs",
        64'({SO, wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err, err_cnt, busy}), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge SCLK);
    #1;

    ecnt = 0;
    for (int k = 0; k < 10; k++) begin
      send(vt[k]);
      if (vt[k].exp_err) ecnt = int'(vt[k].exp_cnt);
    end
    chk("err_cnt_table", 64'(err_cnt), 64'(3));

    // Drive the counter to its ceiling with 1-bit frames, then one more.
    sv = '{32'h0, 1, 1'b0, 7'h00, 8'h00, 1'b0, 7'h00, 8'h00, 1'b1, 8'd0};
    while (ecnt < 255) begin
      ecnt++;
      sv.exp_cnt = 8'(ecnt);
      send(sv);
    end
    chk("err_cnt_255", 64'(err_cnt), 64'(255));
    sv.exp_cnt = 8'hFF;
    send(sv);
    chk("err_cnt_sat", 64'(err_cnt), 64'(255));

    // Reset in the middle of a write frame.
    rb = 16'h07FF;
    for (int i = 0; i < 10; i++) begin
      SV_n = 1'b0;
      SI   = rb[15-i];
      @(posedge SCLK);
      #1;
    end
    chk("busy_pre_reset", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        64'({SO, wr_en, wr_addr, wr_data, rd_req, rd_addr, frame_err, err_cnt, busy}), 64'(0));
    SV_n = 1'b1;
    SI   = 1'b0;
    repeat (2) @(posedge SCLK);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge SCLK);
    #1;
    chk("no_wr_after_reset", 64'(wr_en), 64'(0));

    sv = '{32'h0711, 16, 1'b1, 7'h07, 8'h11, 1'b0, 7'h00, 8'h00, 1'b0, 8'd0};
    send(sv);
    chk("wr_addr_post_reset", 64'(wr_addr), 64'(7));
    chk("wr_data_post_reset", 64'(wr_data), 64'(8'h11));
    chk("err_cnt_post_reset", 64'(err_cnt), 64'(0));

    repeat (3) @(posedge SCLK);
    #1;
    chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
    chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
    chk("err_q_drained", 64'(err_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
